lsu_resp_tracker: RTL



---
 rtl/lsu_resp_tracker_pkg.sv | 38 +++
 rtl/lsu_resp_tracker_beat_counter.sv | 38 +++
 rtl/lsu_resp_tracker.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/lsu_resp_tracker_pkg.sv
// Shared types for the LSU response tracker: capability receive states,
// the main response FSM encoding and the split-access detector.
package lsu_resp_tracker_pkg;

    typedef enum logic [1:0] {
        CRX_IDLE       = 2'd0,
        CRX_WAIT_RESP1 = 2'd1,
        CRX_WAIT_RESP2 = 2'd2
    } cap_rx_fsm_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        WAIT_LAST  = 2'd2,
        FAULT      = 2'd3
    } lsu_resp_fsm_e;

    localparam logic [1:0] TYPE_WORD = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;

    // A transaction needs two bus beats when it crosses a word boundary
    // or when it moves a capability (always two aligned words).
    function automatic logic is_split_access(input logic [1:0] req_type,
                                             input logic [1:0] offset,
                                             input logic       is_cap);
        logic split;
        split = 1'b0;
        if (is_cap) begin
            split = 1'b1;
        end else if (req_type == TYPE_WORD) begin
            split = (offset != 2'b00);
        end else if (req_type == TYPE_HALF) begin
            split = (offset == 2'b11);
        end
        return split;
    endfunction

endpackage

// File: rtl/lsu_resp_tracker_beat_counter.sv
// Up/down counter of granted-but-unanswered bus beats.
module lsu_resp_tracker_beat_counter #(
    parameter int unsigned MaxCount = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [1:0] count_o
);

    localparam logic [1:0] MaxCountQ = 2'(MaxCount);

    logic [1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 2'd0;
        end else begin
            case ({inc_i, dec_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;

    // A response with nothing outstanding, or a grant beyond the bus limit,
    // means the requester broke the protocol.
    overflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
        !(inc_i && !dec_i && (count_q >= MaxCountQ)));

    underflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
        !(dec_i && !inc_i && (count_q == 2'd0)));

endmodule

// File: rtl/lsu_resp_tracker.sv
// Request-side bookkeeping for the CHERIoT LSU: latches transaction attributes,
// first-beat data and capability state, and flags transaction completion.
module lsu_resp_tracker
    import lsu_resp_tracker_pkg::*;
#(
    parameter bit          CHERIoTEn      = 1'b1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cheri_pmode_i,
    input  logic        req_fire_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_type_i,
    input  logic        req_sign_ext_i,
    input  logic [1:0]  req_offset_i,
    input  logic        req_is_cap_i,
    input  logic [3:0]  req_lc_clrperm_i,
    input  logic        req_pmp_err_i,
    input  logic        req_cheri_err_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [32:0] data_rdata_i,
    output logic [23:0] rdata_q,
    output logic [1:0]  rdata_offset_q,
    output logic [1:0]  data_type_q,
    output logic        data_sign_ext_q,
    output logic        data_we_q,
    output logic        resp_is_cap_q,
    output logic [3:0]  resp_lc_clrperm_q,
    output logic        pmp_err_q,
    output logic        cheri_err_q,
    output logic        lsu_err_q,
    output cap_rx_fsm_t cap_rx_fsm_q,
    output logic [32:0] cap_lsw_q,
    output logic        cap_lsw_err_q,
    output logic        outstanding_resp_q,
    output logic        resp_valid_o,
    output logic        busy_o
);

    lsu_resp_fsm_e state_q, state_d;

    logic       req_fault;
    logic       req_cap;
    logic       first_fire;
    logic       first_rvalid;
    logic [1:0] beat_count;

    // Capability accesses only exist in pure-cap mode with CHERIoT enabled.
    assign req_cap      = CHERIoTEn & cheri_pmode_i & req_is_cap_i;
    assign req_fault    = req_pmp_err_i | req_cheri_err_i;
    assign first_fire   = req_fire_i & (state_q == IDLE);
    assign first_rvalid = data_rvalid_i & (state_q == WAIT_FIRST);

    lsu_resp_tracker_beat_counter #(
        .MaxCount (MaxOutstanding)
    ) u_beat_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (req_fire_i & ~req_fault),
        .dec_i   (data_rvalid_i),
        .count_o (beat_count)
    );

    assign outstanding_resp_q = (beat_count != 2'd0);
    assign busy_o             = (state_q != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_fire_i) begin
                    if (req_fault) begin
                        state_d = FAULT;
                    end else if (is_split_access(req_type_i, req_offset_i, req_cap)) begin
                        state_d = WAIT_FIRST;
                    end else begin
                        state_d = WAIT_LAST;
                    end
                end
            end
            WAIT_FIRST: begin
                if (data_rvalid_i) begin
                    state_d = WAIT_LAST;
                end
            end
            WAIT_LAST: begin
                if (data_rvalid_i) begin
                    resp_valid_o = 1'b1;
                    state_d      = IDLE;
                end
            end
            FAULT: begin
                resp_valid_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Attributes are captured only on the first beat; later grants of the
    // same transaction must not disturb what the datapath is consuming.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_offset_q    <= 2'b00;
            data_type_q       <= 2'b00;
            data_sign_ext_q   <= 1'b0;
            data_we_q         <= 1'b0;
            resp_is_cap_q     <= 1'b0;
            resp_lc_clrperm_q <= 4'h0;
            pmp_err_q         <= 1'b0;
            cheri_err_q       <= 1'b0;
        end else if (first_fire) begin
            rdata_offset_q    <= req_offset_i;
            data_type_q       <= req_type_i;
            data_sign_ext_q   <= req_sign_ext_i;
            data_we_q         <= req_we_i;
            resp_is_cap_q     <= req_cap;
            resp_lc_clrperm_q <= req_lc_clrperm_i;
            pmp_err_q         <= req_pmp_err_i;
            cheri_err_q       <= req_cheri_err_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q       <= 24'h0;
            lsu_err_q     <= 1'b0;
            cap_lsw_q     <= 33'h0;
            cap_lsw_err_q <= 1'b0;
        end else if (first_fire) begin
            lsu_err_q <= 1'b0;
        end else if (first_rvalid) begin
            rdata_q   <= data_rdata_i[31:8];
            lsu_err_q <= data_err_i;
            if (resp_is_cap_q) begin
                cap_lsw_q     <= data_rdata_i;
                cap_lsw_err_q <= data_err_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_rx_fsm_q <= CRX_IDLE;
        end else begin
            case (cap_rx_fsm_q)
                CRX_IDLE: begin
                    if (first_fire && req_cap && !req_fault) begin
                        cap_rx_fsm_q <= CRX_WAIT_RESP1;
                    end
                end
                CRX_WAIT_RESP1: begin
                    if (data_rvalid_i) begin
                        cap_rx_fsm_q <= CRX_WAIT_RESP2;
                    end
                end
                CRX_WAIT_RESP2: begin
                    if (data_rvalid_i) begin
                        cap_rx_fsm_q <= CRX_IDLE;
                    end
                end
                default: cap_rx_fsm_q <= CRX_IDLE;
            endcase
        end
    end

endmodule
